// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder.
//   state_t     : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES  : bytes per storage word
//   is_bad_addr : flags misaligned or out-of-range byte addresses
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // An address is bad if it is not word aligned, or if any bit above the
    // word-index field is set. Out-of-range addresses must never alias.
    function automatic logic is_bad_addr(input logic [31:0] addr,
                                         input int unsigned addr_width);
        logic [31:0] hi;
        logic [31:0] low;
        hi  = addr >> (addr_width + 2);
        low = addr & 32'(WORD_BYTES - 1);
        return (low != 32'd0) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the processor datapath (master) and the
// memory responder (slave).
//   req_*  : valid/ready request channel (write flag, byte address, store data)
//   resp_* : valid/ready response channel (load data, error flag)
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_responder_word_ram.sv
// Word storage array: 2**ADDR_WIDTH x 32, synchronous write, asynchronous
// read. Contents are intentionally not reset.
//   clk   : write clock
//   we    : write enable
//   addr  : word index (shared by read and write)
//   wdata : write data
//   rdata : combinational read data at addr
module word_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for processor load/store traffic. Accepts one word
// request, waits WAIT_STATES cycles, then performs the access and holds the
// response until the initiator takes it. Misaligned or out-of-range accesses
// are reported through resp_err and never touch the array.
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : request/response channels (slave side)
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus
);

    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    typedef logic [CNT_W-1:0] cnt_t;

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        enter_resp;
    logic        acc_write;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_bad;
    logic        ram_we;
    logic [31:0] ram_rdata;

    // With zero wait states the access happens on the acceptance edge, before
    // the latches hold anything, so the live request fields are used then.
    assign acc_write = (state_q == IDLE) ? bus.req_write : wr_q;
    assign acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    assign acc_bad   = is_bad_addr(acc_addr, ADDR_WIDTH);
    assign ram_we    = enter_resp && acc_write && !acc_bad;

    word_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (acc_addr[ADDR_WIDTH+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == cnt_t'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latches, wait counter and response registers
    always_comb begin
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q == IDLE && bus.req_valid) begin
            wr_d    = bus.req_write;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            cnt_d   = cnt_t'(WAIT_STATES);
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
        if (enter_resp) begin
            err_d   = acc_bad;
            rdata_d = (!acc_write && !acc_bad) ? ram_rdata : 32'd0;
        end else if (state_q == RESP && bus.resp_ready) begin
            // Clear after the handshake so idle outputs match reset values.
            rdata_d = 32'd0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (WAIT_STATES 2, 0, 3) share one
// stimulus bus; sel chooses which one receives requests and is observed.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        tb_valid = 1'b0;
    logic        tb_write = 1'b0;
    logic [31:0] tb_addr = 32'd0;
    logic [31:0] tb_wdata = 32'd0;
    logic        tb_rready = 1'b0;

    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata;

    int n_chk  = 0;
    int n_pass = 0;
    int ws_tab [3] = '{2, 0, 3};
    logic [31:0] mdl [3][256];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    data_mem_responder_if ifa ();
    data_mem_responder_if ifz ();
    data_mem_responder_if ift ();

    assign ifa.req_valid = tb_valid && (sel == 2'd0);
    assign ifz.req_valid = tb_valid && (sel == 2'd1);
    assign ift.req_valid = tb_valid && (sel == 2'd2);
    assign ifa.req_write = tb_write;  assign ifz.req_write = tb_write;  assign ift.req_write = tb_write;
    assign ifa.req_addr  = tb_addr;   assign ifz.req_addr  = tb_addr;   assign ift.req_addr  = tb_addr;
    assign ifa.req_wdata = tb_wdata;  assign ifz.req_wdata = tb_wdata;  assign ift.req_wdata = tb_wdata;
    assign ifa.resp_ready = tb_rready && (sel == 2'd0);
    assign ifz.resp_ready = tb_rready && (sel == 2'd1);
    assign ift.resp_ready = tb_rready && (sel == 2'd2);

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_z (.clk(clk), .rst(rst), .bus(ifz));
    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(3)) dut_t (.clk(clk), .rst(rst), .bus(ift));

    always_comb begin
        cur_ready = ifa.req_ready;
        cur_valid = ifa.resp_valid;
        cur_rdata = ifa.resp_rdata;
        cur_err   = ifa.resp_err;
        case (sel)
            2'd1: begin
                cur_ready = ifz.req_ready;  cur_valid = ifz.resp_valid;
                cur_rdata = ifz.resp_rdata; cur_err   = ifz.resp_err;
            end
            2'd2: begin
                cur_ready = ift.req_ready;  cur_valid = ift.resp_valid;
                cur_rdata = ift.resp_rdata; cur_err   = ift.resp_err;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (sel=%0d t=%0t)", tag, act, exp, sel, $time);
    endtask

    // Present a request and return just after the acceptance edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        chk("req_ready_idle", 32'(cur_ready), 32'd1);
        tb_valid = 1'b1; tb_write = w; tb_addr = a; tb_wdata = d;
        @(posedge clk); #1;
        tb_valid = 1'b0;
        tb_write = 1'($urandom); tb_addr = $urandom; tb_wdata = $urandom;
    endtask

    // Wait (bounded) for resp_valid; checks the edge count from acceptance.
    task automatic wait_resp();
        int lat;
        lat = 0;
        @(negedge clk);
        while (!cur_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_latency_edges", 32'(lat + 1), 32'(ws_tab[sel] + 1));
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
        logic        bad;
        logic [31:0] er, r0;
        logic [32:0] e;
        logic        e0;
        bad = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
        er  = 32'd0;
        if (!w && !bad) er = mdl[sel][a[9:2]];
        if (w && !bad) mdl[sel][a[9:2]] = d;
        exp_q.push_back({bad, er});
        issue(w, a, d);
        wait_resp();
        r0 = cur_rdata; e0 = cur_err;
        for (int i = 0; i < hold; i++) begin
            tb_valid = (i == 1);
            tb_write = 1'b1; tb_addr = 32'h10; tb_wdata = 32'h0BAD_0BAD;
            @(negedge clk);
            chk("bp_valid", 32'(cur_valid), 32'd1);
            chk("bp_ready", 32'(cur_ready), 32'd0);
            chk("bp_rdata", cur_rdata, r0);
            chk("bp_err",   32'(cur_err), 32'(e0));
        end
        tb_valid = 1'b0;
        e = exp_q.pop_front();
        chk("resp_rdata", cur_rdata, e[31:0]);
        chk("resp_err", 32'(cur_err), 32'(e[32]));
        tb_rready = 1'b1;
        @(posedge clk); #1;
        tb_rready = 1'b0;
        @(negedge clk);
        chk("post_valid", 32'(cur_valid), 32'd0);
        chk("post_ready", 32'(cur_ready), 32'd1);
    endtask

    initial begin
        // Reset held for 3 cycles
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(cur_ready), 32'd1);
        chk("rst_valid", 32'(cur_valid), 32'd0);
        chk("rst_rdata", cur_rdata, 32'd0);
        chk("rst_err",   32'(cur_err), 32'd0);

        // Store/load, misaligned, out-of-range, backpressure (WAIT_STATES=2)
        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        xact(1'b0, 32'h10, 32'h0, 0);
        xact(1'b0, 32'h12, 32'h0, 0);
        xact(1'b1, 32'h0, 32'h1234_5678, 0);
        xact(1'b1, 32'h0000_0402, 32'h1, 0);
        xact(1'b0, 32'h400, 32'h0, 0);
        xact(1'b1, 32'h400, 32'hFFFF_FFFF, 0);
        xact(1'b0, 32'h0, 32'h0, 0);
        xact(1'b0, 32'h10, 32'h0, 5);
        for (int i = 0; i < 6; i++) xact(1'b1, 32'h40 + 32'(i * 4), $urandom, 0);
        for (int i = 5; i >= 0; i--) xact(1'b0, 32'h40 + 32'(i * 4), 32'h0, 0);
        xact(1'b1, 32'h3FC, 32'hA1B2_C3D4, 0);
        xact(1'b0, 32'h3FC, 32'h0, 0);

        // Reset mid-cycle while a committed store's response is pending
        issue(1'b1, 32'h14, 32'hA5A5_5A5A);
        mdl[0][5] = 32'hA5A5_5A5A;
        wait_resp();
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(cur_valid), 32'd0);
        chk("midrst_ready", 32'(cur_ready), 32'd1);
        chk("midrst_err",   32'(cur_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 32'h14, 32'h0, 0);

        // Reset mid-cycle during a pending load response
        issue(1'b0, 32'h10, 32'h0);
        wait_resp();
        chk("preld_rdata", cur_rdata, 32'hDEAD_BEEF);
        #2 rst = 1'b0;
        #1;
        chk("midrst_rdata", cur_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // WAIT_STATES=0
        sel = 2'd1;
        xact(1'b1, 32'h8, 32'hCAFE_0001, 0);
        xact(1'b0, 32'h8, 32'h0, 0);
        xact(1'b0, 32'h9, 32'h0, 2);

        // WAIT_STATES=3, reset during WAIT drops the store
        sel = 2'd2;
        xact(1'b1, 32'h20, 32'h0000_0011, 0);
        issue(1'b1, 32'h20, 32'h0000_0005);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("waitrst_ready", 32'(cur_ready), 32'd1);
        chk("waitrst_valid", 32'(cur_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 32'h20, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
